// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings and constants for the IF/MEM external bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_IF  = 1'b0,
    GRANT_MEM = 1'b1
  } grant_t;

  localparam logic        RST_ENABLE    = 1'b0;
  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic [3:0]  FULL_SEL      = 4'b1111;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Pipeline-side requests and external bus signals of the arbiter.
interface mem_bus_arbiter_if;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_stallreq;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_stallreq;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_error;

  modport master (
    input  flush, if_req, if_addr, mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
           bus_rdata, bus_ack,
    output if_rdata, if_stallreq, mem_rdata, mem_stallreq,
           bus_req, bus_we, bus_addr, bus_sel, bus_wdata, bus_error
  );

  modport slave (
    output flush, if_req, if_addr, mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
           bus_rdata, bus_ack,
    input  if_rdata, if_stallreq, mem_rdata, mem_stallreq,
           bus_req, bus_we, bus_addr, bus_sel, bus_wdata, bus_error
  );
endinterface

// File: rtl/mem_bus_timeout.sv
// Wait-cycle counter; timeout is asserted in the last allowed wait cycle.
module mem_bus_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic timeout
);
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 1'b1;
  end

  assign timeout = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single external bus between instruction fetch and the MEM stage,
// with alternation after back-to-back MEM wins and a bounded wait per access.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic               clk,
  input  logic               rst,
  mem_bus_arbiter_if.master  io
);
  state_t      state, state_next;
  grant_t      last_grant;
  logic        prev_done, discard;
  logic [31:0] if_hold, mem_hold;
  logic        waiting, timeout_raw, done, to_done, disc_eff, grant_mem, grant_if;

  mem_bus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == IDLE),
    .enable (waiting),
    .timeout(timeout_raw)
  );

  always_comb begin
    waiting  = (state != IDLE);
    done     = waiting && (io.bus_ack || timeout_raw);
    to_done  = waiting && !io.bus_ack && timeout_raw;
    // A flush arriving in the completion cycle itself also discards the fetch.
    disc_eff = (state == IF_WAIT) && (discard || io.flush);
    grant_mem = io.mem_req &&
                !(io.if_req && last_grant == GRANT_MEM && prev_done);
    grant_if  = io.if_req && !grant_mem;

    io.if_stallreq  = (rst != RST_ENABLE) && io.if_req &&
                      !((state == IF_WAIT) && done && !disc_eff);
    io.mem_stallreq = (rst != RST_ENABLE) && io.mem_req &&
                      !((state == MEM_WAIT) && done);
    io.if_rdata  = ((state == IF_WAIT)  && io.bus_ack) ? io.bus_rdata : if_hold;
    io.mem_rdata = ((state == MEM_WAIT) && io.bus_ack) ? io.bus_rdata : mem_hold;

    state_next = state;
    unique case (state)
      IDLE:     if (grant_mem)     state_next = MEM_WAIT;
                else if (grant_if) state_next = IF_WAIT;
      IF_WAIT,
      MEM_WAIT: if (done)          state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant   <= GRANT_IF;
      prev_done    <= 1'b0;
      discard      <= 1'b0;
      if_hold      <= ZERO_WORD;
      mem_hold     <= ZERO_WORD;
      io.bus_req   <= 1'b0;
      io.bus_we    <= WRITE_DISABLE;
      io.bus_addr  <= ZERO_WORD;
      io.bus_sel   <= '0;
      io.bus_wdata <= ZERO_WORD;
      io.bus_error <= 1'b0;
    end else begin
      io.bus_error <= to_done;
      prev_done    <= done;
      if (state == IDLE) begin
        if (grant_mem) begin
          io.bus_req   <= 1'b1;
          io.bus_we    <= io.mem_we;
          io.bus_addr  <= io.mem_addr;
          io.bus_sel   <= io.mem_sel;
          io.bus_wdata <= io.mem_wdata;
        end else if (grant_if) begin
          io.bus_req   <= 1'b1;
          io.bus_we    <= WRITE_DISABLE;
          io.bus_addr  <= io.if_addr;
          io.bus_sel   <= FULL_SEL;
          io.bus_wdata <= ZERO_WORD;
        end
      end else if (done) begin
        io.bus_req <= 1'b0;
        last_grant <= (state == MEM_WAIT) ? GRANT_MEM : GRANT_IF;
        // Results are kept only for a requester still asking for them.
        if (state == IF_WAIT) begin
          discard <= 1'b0;
          if (io.if_req && !disc_eff)
            if_hold <= io.bus_ack ? io.bus_rdata : ZERO_WORD;
        end else if (io.mem_req && (to_done || !io.bus_we)) begin
          mem_hold <= io.bus_ack ? io.bus_rdata : ZERO_WORD;
        end
      end else if ((state == IF_WAIT) && io.flush) begin
        discard <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench: transaction-level reference model plus directed literal checks
// followed by randomized traffic with a randomly acking/hanging bus responder.
module tb_mem_bus_arbiter;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_bus_arbiter_if io();
  mem_bus_arbiter #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (.clk(clk), .rst(rst), .io(io));

  int checks = 0;
  int errors = 0;

  // Reference model: owner 0 = bus free, 1 = IF access, 2 = MEM access.
  int          owner = 0;
  int          waited = 0;
  bit          last_mem = 0, prev_done = 0, disc = 0;
  bit          m_done, m_to, m_de;
  logic [31:0] hold_if = '0, hold_mem = '0, m_addr = '0, m_wdata = '0;
  logic        m_req = 0, m_we = 0, m_err = 0;
  logic [3:0]  m_sel = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner = 0; waited = 0; last_mem = 0; prev_done = 0; disc = 0;
      hold_if = '0; hold_mem = '0; m_addr = '0; m_wdata = '0;
      m_req = 0; m_we = 0; m_err = 0; m_sel = '0;
    end else begin
      m_done = (owner != 0) && (io.bus_ack || waited == T - 1);
      m_to   = m_done && !io.bus_ack;
      m_de   = (owner == 1) && (disc || io.flush);
      m_err  = m_to;
      if (owner != 0) begin
        if (m_done) begin
          if (owner == 1) begin
            if (io.if_req && !m_de) hold_if = io.bus_ack ? io.bus_rdata : 32'h0;
            disc = 0;
          end else if (io.mem_req) begin
            if (!io.bus_ack)  hold_mem = 32'h0;
            else if (!m_we)   hold_mem = io.bus_rdata;
          end
          last_mem = (owner == 2);
          owner = 0; m_req = 0; waited = 0;
        end else begin
          waited++;
          if (owner == 1 && io.flush) disc = 1;
        end
        prev_done = m_done;
      end else begin
        if (io.mem_req && !(io.if_req && last_mem && prev_done)) begin
          owner = 2; m_we = io.mem_we; m_addr = io.mem_addr;
          m_sel = io.mem_sel; m_wdata = io.mem_wdata;
        end else if (io.if_req) begin
          owner = 1; m_we = 0; m_addr = io.if_addr; m_sel = 4'hF; m_wdata = '0;
        end
        if (owner != 0) begin m_req = 1; waited = 0; end
        prev_done = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    bit e_done, e_de;
    e_done = (owner != 0) && (io.bus_ack || waited == T - 1);
    e_de   = (owner == 1) && (disc || io.flush);
    chk("if_stallreq", 32'(io.if_stallreq),
        32'(rst && io.if_req && !(owner == 1 && e_done && !e_de)));
    chk("mem_stallreq", 32'(io.mem_stallreq),
        32'(rst && io.mem_req && !(owner == 2 && e_done)));
    chk("if_rdata", io.if_rdata, (owner == 1 && io.bus_ack) ? io.bus_rdata : hold_if);
    chk("mem_rdata", io.mem_rdata, (owner == 2 && io.bus_ack) ? io.bus_rdata : hold_mem);
    chk("bus_req", 32'(io.bus_req), 32'(m_req));
    chk("bus_we", 32'(io.bus_we), 32'(m_we));
    chk("bus_addr", io.bus_addr, m_addr);
    chk("bus_sel", 32'(io.bus_sel), 32'(m_sel));
    chk("bus_wdata", io.bus_wdata, m_wdata);
    chk("bus_error", 32'(io.bus_error), 32'(m_err));
  endtask

  task automatic drive(input bit ir, input bit mr, input bit we, input bit fl,
                       input bit ak, input logic [31:0] rd);
    @(negedge clk);
    io.if_req = ir; io.mem_req = mr; io.mem_we = we; io.flush = fl;
    io.bus_ack = ak; io.bus_rdata = rd;
    #1 check_all();
  endtask

  logic [31:0] grants[$];
  int          wait_cnt;
  bit          seen_err, hang, prev_breq;

  initial begin
    io.flush = 0; io.if_req = 0; io.if_addr = '0; io.mem_req = 0; io.mem_we = 0;
    io.mem_addr = '0; io.mem_sel = '0; io.mem_wdata = '0; io.bus_rdata = '0; io.bus_ack = 0;
    repeat (2) @(negedge clk);
    #1 check_all();
    chk("reset bus_req", 32'(io.bus_req), 32'h0);
    chk("reset if_rdata", io.if_rdata, 32'h0);
    @(negedge clk) rst = 1'b1;

    // IF-only read
    io.if_addr = 32'h100;
    drive(1, 0, 0, 0, 0, 0);
    chk("t1 stall grant", 32'(io.if_stallreq), 32'h1);
    drive(1, 0, 0, 0, 0, 0);
    chk("t1 bus_addr", io.bus_addr, 32'h100);
    chk("t1 bus_sel", 32'(io.bus_sel), 32'hF);
    chk("t1 bus_we", 32'(io.bus_we), 32'h0);
    chk("t1 stall wait", 32'(io.if_stallreq), 32'h1);
    drive(1, 0, 0, 0, 1, 32'h2401_0005);
    chk("t1 stall ack", 32'(io.if_stallreq), 32'h0);
    chk("t1 rdata ack", io.if_rdata, 32'h2401_0005);
    drive(0, 0, 0, 0, 0, 0);
    chk("t1 rdata hold", io.if_rdata, 32'h2401_0005);

    // Contention: MEM store first, then IF
    io.mem_addr = 32'h200; io.mem_wdata = 32'hDEAD_BEEF; io.mem_sel = 4'b0011;
    io.if_addr = 32'h104;
    drive(1, 1, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0);
    chk("t2 mem we", 32'(io.bus_we), 32'h1);
    chk("t2 mem sel", 32'(io.bus_sel), 32'h3);
    chk("t2 mem wdata", io.bus_wdata, 32'hDEAD_BEEF);
    drive(1, 1, 1, 0, 1, 32'h0);
    chk("t2 mem stall ack", 32'(io.mem_stallreq), 32'h0);
    chk("t2 if stall", 32'(io.if_stallreq), 32'h1);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    chk("t2 if addr", io.bus_addr, 32'h104);
    drive(1, 0, 0, 0, 1, 32'h0000_A5A5);
    chk("t2 if stall ack", 32'(io.if_stallreq), 32'h0);
    chk("t2 store keeps mem_rdata", io.mem_rdata, 32'h0);

    // Alternation with both requesters held high and immediate acks
    io.mem_addr = 32'h300; io.if_addr = 32'h400;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      io.if_req = 1; io.mem_req = 1; io.mem_we = 0; io.flush = 0;
      io.bus_ack = io.bus_req; io.bus_rdata = $urandom;
      #1 check_all();
      if (io.bus_req) grants.push_back(io.bus_addr);
    end
    chk("t3 grants", 32'(grants.size() >= 3), 32'h1);
    if (grants.size() >= 3) begin
      chk("t3 grant0", grants[0], 32'h300);
      chk("t3 grant1", grants[1], 32'h400);
      chk("t3 grant2", grants[2], 32'h300);
    end
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0);

    // Timeout on an IF read that is never acknowledged
    io.if_addr = 32'h500;
    drive(1, 0, 0, 0, 0, 0);
    wait_cnt = 0; seen_err = 0;
    for (int i = 0; i < 40 && !seen_err; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      if (io.bus_error) seen_err = 1;
      else if (io.bus_req) wait_cnt++;
    end
    chk("t4 error seen", 32'(seen_err), 32'h1);
    chk("t4 wait cycles", 32'(wait_cnt), 32'(T));
    chk("t4 if_rdata", io.if_rdata, 32'h0);
    drive(0, 0, 0, 0, 1, 32'h7777_7777);
    drive(0, 0, 0, 0, 0, 0);
    chk("t4 error one cycle", 32'(io.bus_error), 32'h0);

    // Flush one cycle into IF_WAIT
    io.if_addr = 32'h600;
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 1, 32'h1234);
    chk("t5 stall on discard", 32'(io.if_stallreq), 32'h1);
    drive(1, 0, 0, 0, 0, 0);
    chk("t5 hold unchanged", io.if_rdata, 32'h0);
    drive(1, 0, 0, 0, 0, 0);
    chk("t5 regrant", 32'(io.bus_req), 32'h1);
    drive(1, 0, 0, 0, 1, 32'h5678);
    chk("t5 fresh data", io.if_rdata, 32'h5678);
    chk("t5 fresh stall", 32'(io.if_stallreq), 32'h0);

    // Asynchronous reset in the middle of MEM_WAIT
    io.mem_addr = 32'h700;
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    chk("t6 busy", 32'(io.bus_req), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("t6 bus_req", 32'(io.bus_req), 32'h0);
    chk("t6 mem stall", 32'(io.mem_stallreq), 32'h0);
    chk("t6 if stall", 32'(io.if_stallreq), 32'h0);
    chk("t6 bus_error", 32'(io.bus_error), 32'h0);
    drive(0, 1, 0, 0, 0, 0);
    rst = 1'b1;
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 32'hCAFE);
    chk("t6 after reset", io.mem_rdata, 32'hCAFE);

    // Randomized traffic
    hang = 0; prev_breq = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (io.bus_req && !prev_breq) hang = ($urandom_range(0, 99) < 6);
      prev_breq = io.bus_req;
      io.if_req    = ($urandom_range(0, 99) < 70);
      io.mem_req   = ($urandom_range(0, 99) < 50);
      io.mem_we    = $urandom_range(0, 1);
      io.if_addr   = $urandom;
      io.mem_addr  = $urandom;
      io.mem_sel   = 4'($urandom);
      io.mem_wdata = $urandom;
      io.flush     = ($urandom_range(0, 99) < 8);
      io.bus_rdata = $urandom;
      io.bus_ack   = io.bus_req && !hang && ($urandom_range(0, 99) < 45);
      #1 check_all();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external SRAM/bus port between instruction fetch (IF) and the MEM stage (loads/stores).
- Sequences each access through a request/ack handshake.
- Raises per-requester stall requests toward the pipeline controller. This sets the stall[5:0] vector that holds the EX/MEM register.
- Resolves the IF-vs-MEM structural hazard, with a bounded-wait timeout.

Parameters:
- TIMEOUT_CYCLES, 16: cycles in a WAIT state without bus_ack before the access is abandoned.
- CNT_W, 5: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low (0 = reset)
- flush  in  1  pipeline flush (exception/ERET); discards the in-flight IF result
- if_req  in  1  IF requests an instruction read
- if_addr  in  32  IF read address
- if_rdata  out  32  instruction returned to IF
- if_stallreq  out  1  IF must hold
- mem_req  in  1  MEM stage requests an access
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  32  MEM access address
- mem_sel  in  4  byte enables
- mem_wdata  in  32  store data
- mem_rdata  out  32  load data returned to MEM
- mem_stallreq  out  1  MEM must hold
- bus_req  out  1  external access request
- bus_we  out  1  external write enable
- bus_addr  out  32  external address
- bus_sel  out  4  external byte enables
- bus_wdata  out  32  external write data
- bus_rdata  in  32  external read data, valid with bus_ack
- bus_ack  in  1  access complete this cycle
- bus_error  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; counter=0; last_grant=IF; discard=0.
  - bus_req/bus_we/bus_error = 0; bus_addr/bus_sel/bus_wdata = 0.
  - if_rdata and mem_rdata holding registers = 0.
  - Reset mid-access aborts it silently; no bus_error.
- States: IDLE, IF_WAIT, MEM_WAIT.
- IDLE arbitration at the clock edge:
  - If both if_req and mem_req are high: MEM wins, unless last_grant=MEM and the previous cycle completed a MEM access. In that case IF wins (alternation, so IF cannot starve).
  - If only one request is high, that requester wins.
  - The winner's address, sel, we and wdata are registered onto the bus outputs, bus_req<=1, and state moves to X_WAIT.
  - IF accesses always drive bus_we=0 and bus_sel=4'b1111.
- X_WAIT:
  - Bus outputs are held stable until bus_ack.
  - On bus_ack: bus_req<=0 and state returns to IDLE at the next edge. last_grant<=X. bus_rdata is latched into that requester's holding register for a read; for a write the holding register is unchanged.
  - The counter increments each WAIT cycle without ack.
  - When counter reaches TIMEOUT_CYCLES-1 with no ack: bus_error pulses for 1 cycle, the holding register is loaded with 0, the access counts as completed, and state returns to IDLE.
- Stall outputs (combinational):
  - X_stallreq = X_req && !(state==X_WAIT && (bus_ack || timeout)).
  - X_stallreq is therefore high in the grant cycle and throughout the wait, and low in the completion cycle.
- Read data (combinational): X_rdata = bus_rdata when state==X_WAIT && bus_ack, otherwise the holding register. Data is valid in the same cycle the stall drops.
- Minimum latency: request seen in cycle 0 (IDLE), bus_req high from cycle 1, ack in cycle 1 completes the access, and the pipeline advances at the end of cycle 1.
- Flush:
  - During IF_WAIT: set discard. The bus access still completes (no abort).
  - When it completes: discard the result (holding register not updated), clear discard, and keep if_stallreq high through the completion cycle so IF re-requests.
  - During MEM_WAIT: no effect. A committed store completes.
  - In IDLE: no effect.
- Requester deasserts mid-wait: the access still completes and the result is dropped. req is sampled only in IDLE.
- Simultaneous bus_ack and timeout: ack wins, no bus_error.

Decomposition:
- Shared constants in defines.v:
  - state encodings (2-bit) for IDLE, IF_WAIT, MEM_WAIT;
  - grant encodings (1-bit) for IF and MEM;
  - the existing RstEnable/WriteDisable/ZeroWord constants.
- One natural sub-module: mem_bus_timeout. It holds the CNT_W counter with clear/enable inputs and a timeout output, and is reset asynchronously by rst.

Test Plan:
1. IF only: if_req=1, addr 0x100, bus_ack 2 cycles after bus_req with rdata 0x24010005 -> if_stallreq high 2 cycles; if_rdata=0x24010005 with stall low in the ack cycle; bus_we=0, bus_sel=4'b1111.
2. Contention: if_req and mem_req high together; MEM is a store of 0xDEADBEEF to 0x200 with sel 4'b0011 -> MEM granted first (bus_we=1, sel 0011); IF granted next; if_stallreq high until the IF ack.
3. Alternation: mem_req held high across two consecutive completions while if_req is high -> grant order MEM, IF, MEM.
4. Timeout: IF read, bus_ack never asserted -> bus_error pulses once TIMEOUT_CYCLES=16 cycles after bus_req rises; if_rdata=0; state back in IDLE.
5. Flush: assert flush 1 cycle into IF_WAIT; ack with rdata 0x1234 -> if_rdata holding register unchanged; if_stallreq high in the completion cycle; a fresh if_req is then granted.
6. Async reset: pull rst low mid MEM_WAIT, between clock edges -> bus_req=0 immediately, both stallreqs 0, no bus_error, and normal operation after release.
